// File: rtl/circular_queue.sv
// In-order instruction queue: circular FIFO of decoded-instruction records between decode and dispatch.
// Optional simulation trace of accepted/rejected requests when CIRCULAR_QUEUE_DEBUG_EN is defined.
module circular_queue #(
   parameter int queueIndexBits          = 3,
   parameter int addressWidth            = 64,
   parameter int opcodeSize              = 12,
   parameter int funcUnitCodeSize        = 3,
   parameter int instructionCounterWidth = 64,
   parameter int instMinIdWidth          = 7,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int regAccessPatternSize    = 2
) (
   input  logic                                  clock_i,
   input  logic                                  reset_i,
   input  logic                                  writeEnable_i,
   input  logic [0:24]                           instFormat_i,
   input  logic [0:opcodeSize-1]                 opcode_i,
   input  logic [0:addressWidth-1]               address_i,
   input  logic [0:funcUnitCodeSize-1]           funcUnitType_i,
   input  logic [0:instructionCounterWidth-1]    majID_i,
   input  logic [0:instMinIdWidth-1]             minID_i,
   input  logic                                  is64Bit_i,
   input  logic [0:PidSize-1]                    pid_i,
   input  logic [0:TidSize-1]                    tid_i,
   input  logic [0:regAccessPatternSize*4-1]     operandRW_i,
   input  logic [0:3]                            operandIsReg_i,
   input  logic [0:83]                           body_i,
   input  logic                                  readEnable_i,
   output logic [0:24]                           instFormat_o,
   output logic [0:opcodeSize-1]                 opcode_o,
   output logic [0:addressWidth-1]               address_o,
   output logic [0:funcUnitCodeSize-1]           funcUnitType_o,
   output logic [0:instructionCounterWidth-1]    majID_o,
   output logic [0:instMinIdWidth-1]             minID_o,
   output logic                                  is64Bit_o,
   output logic [0:PidSize-1]                    pid_o,
   output logic [0:TidSize-1]                    tid_o,
   output logic [0:regAccessPatternSize*4-1]     operandRW_o,
   output logic [0:3]                            operandIsReg_o,
   output logic [0:83]                           body_o,
   output logic [queueIndexBits-1:0]             head_o,
   output logic [queueIndexBits-1:0]             tail_o,
   output logic                                  isEmpty_o,
   output logic                                  isFull_o
);

   localparam int depth       = 2 ** queueIndexBits;
   localparam int recordWidth = 25 + opcodeSize + addressWidth + funcUnitCodeSize
                              + instructionCounterWidth + instMinIdWidth + 1 + PidSize
                              + TidSize + regAccessPatternSize*4 + 4 + 84;
   localparam logic [queueIndexBits:0] fullCount = {1'b1, {queueIndexBits{1'b0}}};

   logic [recordWidth-1:0]  storage [depth];
   logic [recordWidth-1:0]  inRecord;
   logic [recordWidth-1:0]  outRecord;
   logic [queueIndexBits-1:0] head;
   logic [queueIndexBits-1:0] tail;
   logic [queueIndexBits:0]   count;
   logic                      doWrite;
   logic                      doRead;

   assign inRecord = {instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
                      is64Bit_i, pid_i, tid_i, operandRW_i, operandIsReg_i, body_i};

   assign {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
           is64Bit_o, pid_o, tid_o, operandRW_o, operandIsReg_o, body_o} = outRecord;

   // Flags come from the registered count, so a full queue rejects a write even when a read drains it this cycle.
   assign isEmpty_o = (count == '0);
   assign isFull_o  = (count == fullCount);
   assign doWrite   = writeEnable_i && !isFull_o;
   assign doRead    = readEnable_i && !isEmpty_o;
   assign head_o    = head;
   assign tail_o    = tail;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         outRecord <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the
         // read of storage[head] below never sees a write landing in the same cycle.
         if (doWrite) tail <= tail + 1'b1;
         if (doRead) begin
            head      <= head + 1'b1;
            outRecord <= storage[head];
         end
         case ({doWrite, doRead})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the record array has no reset; head/tail/count define which entries are valid,
   // and leaving it out lets the array map onto plain RAM.
   always_ff @(posedge clock_i) begin
      if (!reset_i && doWrite) storage[tail] <= inRecord;
   end

`ifdef CIRCULAR_QUEUE_DEBUG_EN
   localparam int minLsb = 1 + PidSize + TidSize + regAccessPatternSize*4 + 4 + 84;
   localparam int majLsb = minLsb + instMinIdWidth;
   logic [recordWidth-1:0] headRecord;
   assign headRecord = storage[head];

   always @(posedge clock_i) begin
      if (!reset_i) begin
         if (doWrite)
            $display("%t circular_queue: enq ptr=%0d majID=%0h minID=%0h", $time, tail, majID_i, minID_i);
         else if (writeEnable_i)
            $display("%t circular_queue: write rejected, queue full", $time);
         if (doRead)
            $display("%t circular_queue: deq ptr=%0d majID=%0h minID=%0h", $time, head,
                     headRecord[majLsb +: instructionCounterWidth], headRecord[minLsb +: instMinIdWidth]);
         else if (readEnable_i)
            $display("%t circular_queue: read rejected, queue empty", $time);
      end
   end
`endif

endmodule

// File: tb/tb_circular_queue.sv
// Directed, table-driven bench for circular_queue: fill/drain, wrap, full/empty rejection,
// simultaneous read/write and mid-fill reset, with every record field checked.
module tb_circular_queue;

   logic          clock_i = 1'b0;
   logic          reset_i, writeEnable_i, readEnable_i;
   logic [0:24]   instFormat_i, instFormat_o;
   logic [0:11]   opcode_i, opcode_o;
   logic [0:63]   address_i, address_o;
   logic [0:2]    funcUnitType_i, funcUnitType_o;
   logic [0:63]   majID_i, majID_o;
   logic [0:6]    minID_i, minID_o;
   logic          is64Bit_i, is64Bit_o;
   logic [0:19]   pid_i, pid_o;
   logic [0:15]   tid_i, tid_o;
   logic [0:7]    operandRW_i, operandRW_o;
   logic [0:3]    operandIsReg_i, operandIsReg_o;
   logic [0:83]   body_i, body_o;
   logic [2:0]    head_o, tail_o;
   logic          isEmpty_o, isFull_o;

   int checks = 0;
   int errors = 0;

   always #5 clock_i = ~clock_i;

   circular_queue dut (
      .clock_i(clock_i), .reset_i(reset_i), .writeEnable_i(writeEnable_i),
      .instFormat_i(instFormat_i), .opcode_i(opcode_i), .address_i(address_i),
      .funcUnitType_i(funcUnitType_i), .majID_i(majID_i), .minID_i(minID_i),
      .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i), .operandRW_i(operandRW_i),
      .operandIsReg_i(operandIsReg_i), .body_i(body_i), .readEnable_i(readEnable_i),
      .instFormat_o(instFormat_o), .opcode_o(opcode_o), .address_o(address_o),
      .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
      .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o), .operandRW_o(operandRW_o),
      .operandIsReg_o(operandIsReg_o), .body_o(body_o), .head_o(head_o), .tail_o(tail_o),
      .isEmpty_o(isEmpty_o), .isFull_o(isFull_o)
   );

   // Secondary record fields are derived from majID so every field of a dequeued record is checkable.
   function automatic logic [24:0] fmtOf(input logic [63:0] m);  return 25'(m * 3 + 1); endfunction
   function automatic logic [2:0]  fuOf(input logic [63:0] m);   return 3'(m);          endfunction
   function automatic logic [6:0]  minOf(input logic [63:0] m);  return 7'(m + 5);      endfunction
   function automatic logic        is64Of(input logic [63:0] m); return m[0];           endfunction
   function automatic logic [19:0] pidOf(input logic [63:0] m);  return 20'(m * 7);     endfunction
   function automatic logic [15:0] tidOf(input logic [63:0] m);  return 16'(m * 11);    endfunction
   function automatic logic [7:0]  rwOf(input logic [63:0] m);   return 8'(m) ^ 8'hA5;  endfunction
   function automatic logic [3:0]  isRegOf(input logic [63:0] m); return 4'(m);         endfunction

   typedef struct {
      logic        rst, we, re;
      logic [63:0] maj, addr;
      logic [11:0] op;
      logic [83:0] body;
      logic [2:0]  eHead, eTail;
      logic        eEmpty, eFull, eZero;
      logic [63:0] eMaj, eAddr;
      logic [11:0] eOp;
      logic [83:0] eBody;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, we, re, input logic [63:0] maj, addr, input logic [11:0] op,
                      input logic [83:0] body, input logic [2:0] eHead, eTail,
                      input logic eEmpty, eFull, eZero, input logic [63:0] eMaj, eAddr,
                      input logic [11:0] eOp, input logic [83:0] eBody);
      vec_t v;
      v.rst = rst; v.we = we; v.re = re; v.maj = maj; v.addr = addr; v.op = op; v.body = body;
      v.eHead = eHead; v.eTail = eTail; v.eEmpty = eEmpty; v.eFull = eFull; v.eZero = eZero;
      v.eMaj = eMaj; v.eAddr = eAddr; v.eOp = eOp; v.eBody = eBody;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset_i = v.rst; writeEnable_i = v.we; readEnable_i = v.re;
      majID_i = v.maj; address_i = v.addr; opcode_i = v.op; body_i = v.body;
      instFormat_i = fmtOf(v.maj); funcUnitType_i = fuOf(v.maj); minID_i = minOf(v.maj);
      is64Bit_i = is64Of(v.maj); pid_i = pidOf(v.maj); tid_i = tidOf(v.maj);
      operandRW_i = rwOf(v.maj); operandIsReg_i = isRegOf(v.maj);
   endtask

   task automatic compare(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      check({t, " head"}, 128'(head_o), 128'(v.eHead));
      check({t, " tail"}, 128'(tail_o), 128'(v.eTail));
      check({t, " empty"}, 128'(isEmpty_o), 128'(v.eEmpty));
      check({t, " full"}, 128'(isFull_o), 128'(v.eFull));
      if (v.eZero) begin
         check({t, " zeroRecord"}, 128'(|{instFormat_o, opcode_o, address_o, funcUnitType_o,
               majID_o, minID_o, is64Bit_o, pid_o, tid_o, operandRW_o, operandIsReg_o, body_o}), 128'(0));
      end else begin
         check({t, " majID"}, 128'(majID_o), 128'(v.eMaj));
         check({t, " address"}, 128'(address_o), 128'(v.eAddr));
         check({t, " opcode"}, 128'(opcode_o), 128'(v.eOp));
         check({t, " body"}, 128'(body_o), 128'(v.eBody));
         check({t, " instFormat"}, 128'(instFormat_o), 128'(fmtOf(v.eMaj)));
         check({t, " funcUnit"}, 128'(funcUnitType_o), 128'(fuOf(v.eMaj)));
         check({t, " minID"}, 128'(minID_o), 128'(minOf(v.eMaj)));
         check({t, " is64Bit"}, 128'(is64Bit_o), 128'(is64Of(v.eMaj)));
         check({t, " pid"}, 128'(pid_o), 128'(pidOf(v.eMaj)));
         check({t, " tid"}, 128'(tid_o), 128'(tidOf(v.eMaj)));
         check({t, " operandRW"}, 128'(operandRW_o), 128'(rwOf(v.eMaj)));
         check({t, " operandIsReg"}, 128'(operandIsReg_o), 128'(isRegOf(v.eMaj)));
      end
   endtask

   initial begin
      logic [83:0] b0;
      b0 = 84'hFFFF0000_0000FFFF_0000F;

      //   rst we re maj addr op body  | head tail emp full zero  eMaj eAddr eOp eBody
      add(1, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 1,  0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, b0,           0, 1, 0, 0, 1,  0, 0, 0, 0);
      add(0, 1, 0, 1, 4, 1, 0,            0, 2, 0, 0, 1,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,            1, 2, 0, 0, 0,  0, 0, 0, b0);
      add(0, 0, 1, 0, 0, 0, 0,            2, 2, 1, 0, 0,  1, 4, 1, 0);
      // Eight writes wrap tail from 2 back to 2 and fill the queue.
      for (int i = 0; i < 8; i++)
         add(0, 1, 0, 64'(i), 64'(4*i), 12'(i), 84'(i),
             2, 3'((3 + i) % 8), 0, (i == 7), 0, 1, 4, 1, 0);
      add(0, 1, 0, 9, 36, 9, 9,           2, 2, 0, 1, 0,  1, 4, 1, 0);
      // Full + simultaneous read/write: write rejected, read accepted.
      add(0, 1, 1, 99, 99, 99, 99,        3, 2, 0, 0, 0,  0, 0, 0, 0);
      for (int k = 1; k < 8; k++)
         add(0, 0, 1, 0, 0, 0, 0,
             3'((3 + k) % 8), 2, (k == 7), 0, 0, 64'(k), 64'(4*k), 12'(k), 84'(k));
      add(0, 0, 1, 0, 0, 0, 0,            2, 2, 1, 0, 0,  7, 28, 7, 7);
      // Empty + simultaneous read/write: entry stored, outputs hold.
      add(0, 1, 1, 20, 80, 20, 20,        2, 3, 0, 0, 0,  7, 28, 7, 7);
      add(0, 1, 0, 21, 84, 21, 21,        2, 4, 0, 0, 0,  7, 28, 7, 7);
      add(0, 1, 0, 22, 88, 22, 22,        2, 5, 0, 0, 0,  7, 28, 7, 7);
      add(0, 1, 1, 23, 92, 23, 23,        3, 6, 0, 0, 0, 20, 80, 20, 20);
      add(0, 1, 1, 24, 96, 24, 24,        4, 7, 0, 0, 0, 21, 84, 21, 21);
      add(0, 1, 0, 25, 100, 25, 25,       4, 0, 0, 0, 0, 21, 84, 21, 21);
      // Reset with four entries, overriding a same-cycle read and write.
      add(1, 1, 1, 26, 104, 26, 26,       0, 0, 1, 0, 1,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,            0, 0, 1, 0, 1,  0, 0, 0, 0);
      add(0, 1, 0, 30, 120, 30, 30,       0, 1, 0, 0, 1,  0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0,            1, 1, 1, 0, 0, 30, 120, 30, 30);

      drive(vecs[0]);
      @(negedge clock_i);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(posedge clock_i);
         #1;
         compare(i, vecs[i]);
      end

      // Hand sequence: write-to-output latency is two edges with no bypass.
      drive(vecs[vecs.size()-1]);
      reset_i = 1'b0; readEnable_i = 1'b0; writeEnable_i = 1'b1;
      majID_i = 64'd40; address_i = 64'd160; opcode_i = 12'd40;
      @(posedge clock_i); #1;
      writeEnable_i = 1'b0; readEnable_i = 1'b1;
      check("noBypass majID", 128'(majID_o), 128'(30));
      @(posedge clock_i); #1;
      readEnable_i = 1'b0;
      check("latency2 majID", 128'(majID_o), 128'(40));
      check("latency2 address", 128'(address_o), 128'(160));
      check("latency2 empty", 128'(isEmpty_o), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
